// File: rtl/irq_pending_latch_if.sv
// Request/acknowledge bundle between the interrupt source side and irq_pending_latch.
// master drives requests, mask and acknowledges; slave is the latch itself.
interface irq_pending_latch_if;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_idx;
    logic       ovr_clr;
    logic [3:0] pend;
    logic       irq;
    logic [3:0] overrun;

    modport master (
        output req_in, mask, ack, ack_idx, ovr_clr,
        input  pend, irq, overrun
    );

    modport slave (
        input  req_in, mask, ack, ack_idx, ovr_clr,
        output pend, irq, overrun
    );
endinterface

// File: rtl/irq_pending_latch.sv
// Four-channel interrupt front end: synchronize, edge-detect, hold pending until acked by index.
// Define IRQ_OVERRUN_EN to build the sticky per-channel overrun flags and their ovr_clr logic.
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    irq_pending_latch_if.slave bus
);

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] prev_q;
    logic [3:0] pnd_q;
    logic [3:0] pnd_d;
    logic [3:0] rise;
    logic [3:0] ack_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= 4'b0000;
            end
            prev_q <= 4'b0000;
        end else begin
            sync_q[0] <= bus.req_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A new event beats a same-cycle acknowledge of the same channel.
    always_comb begin
        rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
        ack_hit = 4'b0000;
        if (bus.ack) begin
            ack_hit = 4'b0001 << bus.ack_idx;
        end
        pnd_d = rise | (pnd_q & ~ack_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pnd_q <= 4'b0000;
        end else begin
            pnd_q <= pnd_d;
        end
    end

    assign bus.pend = pnd_q & bus.mask;
    assign bus.irq  = |(pnd_q & bus.mask);

`ifdef IRQ_OVERRUN_EN
    logic [3:0] ovr_q;
    logic [3:0] ovr_set;
    logic [3:0] ovr_d;

    // A fresh overrun survives a same-cycle clear.
    always_comb begin
        ovr_set = rise & pnd_q & ~ack_hit;
        if (bus.ovr_clr) begin
            ovr_d = ovr_set;
        end else begin
            ovr_d = ovr_q | ovr_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 4'b0000;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign bus.overrun = ovr_q;
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = bus.ovr_clr;
    assign bus.overrun    = 4'b0000;
`endif

endmodule
